// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA/STATUS registers, byte FIFO, 8N1 serialiser (LSB first).
// Optional even parity bit between data and stop when MMIO_UART_TX_PARITY_EN is defined.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_sig,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        busy
);

  localparam int          PW          = $clog2(FIFO_DEPTH);
  localparam int          CW          = PW + 1;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [15:0] BAUD_LAST   = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MMIO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [15:0]   baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          overflow;
  logic          tx_q;

  logic data_wr, status_wr, fifo_empty, fifo_full, baud_done, pop, push;
  logic unused_wr_data;

  assign data_wr    = wr_sig && (addr == BASE_ADDR);
  assign status_wr  = wr_sig && (addr == STATUS_ADDR);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign baud_done  = (baud == BAUD_LAST);
  // A pop frees a slot on the same edge, so a full FIFO still accepts a push then.
  assign pop  = !fifo_empty && ((state == S_IDLE) || (state == S_STOP && baud_done));
  assign push = data_wr && (!fifo_full || pop);

  assign tx   = tx_q;
  assign busy = (state != S_IDLE);
  assign unused_wr_data = ^wr_data[31:8];

  // NOTE: FIFO storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (data_wr && !push)               overflow <= 1'b1;
      else if (status_wr && wr_data[3])   overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= S_START;
            baud  <= '0;
            tx_q  <= 1'b0;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
            tx_q    <= shift[0];
          end else begin
            baud <= baud + 16'd1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              state <= S_PARITY;
              tx_q  <= ^shift;
`else
              state <= S_STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shift[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            baud  <= '0;
            state <= S_STOP;
            tx_q  <= 1'b1;
          end else begin
            baud <= baud + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (baud_done) begin
            baud <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= S_START;
              tx_q  <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    rd_data = '0;
    if (addr == STATUS_ADDR)
      rd_data = {16'h0000, 8'(count), 4'h0, overflow, busy, fifo_empty, fifo_full};
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame timing, back-to-back, overflow, reset, decode.
module tb_mmio_uart_tx;

  localparam int          CLK_DIV     = 4;
  localparam logic [31:0] BASE        = 32'h0000_1000;
  localparam logic [31:0] STATUS      = 32'h0000_1004;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int          NBITS       = 11;
`else
  localparam int          NBITS       = 10;
`endif
  localparam int          FRAME       = NBITS * CLK_DIV;

  logic        clk;
  logic        reset;
  logic        wr_sig;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        tx;
  logic        busy;

  int passed = 0;
  int total  = 0;

  mmio_uart_tx #(
    .BASE_ADDR (BASE),
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_sig (wr_sig),
    .addr   (addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .tx     (tx),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; the store is captured on the following rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr    = a;
    wr_data = d;
    wr_sig  = 1'b1;
    @(negedge clk);
    wr_sig  = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    addr   = a;
    wr_sig = 1'b0;
    #1;
    d = rd_data;
  endtask

  // Waits (bounded) for a start bit, then samples every cycle of the frame.
  task automatic capture_frame(output logic [7:0] d, output logic ok,
                               output logic par, output int gap);
    logic [10:0] bits;
    int n;
    d = '0; ok = 1'b1; par = 1'b0; gap = 0; bits = '0; n = 0;
    while (tx !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    gap = n;
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (c == 0) bits[b] = tx;
        else if (tx !== bits[b]) ok = 1'b0;
      end
    end
    if (bits[0] !== 1'b0 || bits[NBITS-1] !== 1'b1) ok = 1'b0;
    d   = bits[8:1];
    par = bits[9];
  endtask

  task automatic test_reset;
    logic [31:0] st;
    reset = 1'b1; wr_sig = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      read_reg(STATUS, st);
      total++;
      if (tx !== 1'b1) $display("FAIL reset_tx cycle %0d: got %b expected 1", i, tx);
      else passed++;
      total++;
      if (busy !== 1'b0) $display("FAIL reset_busy cycle %0d: got %b expected 0", i, busy);
      else passed++;
      total++;
      if (st !== 32'h0000_0002) $display("FAIL reset_status cycle %0d: got %h expected 00000002", i, st);
      else passed++;
    end
  endtask

  task automatic test_single_frame;
    logic [31:0] st;
    logic [7:0]  d;
    logic        ok, par;
    int          gap;
    bus_write(BASE, 32'hFFFF_FF55);
    read_reg(STATUS, st);
    total++;
    if (st !== 32'h0000_0100) $display("FAIL single_status_after_push: got %h expected 00000100", st);
    else passed++;
    capture_frame(d, ok, par, gap);
    total++;
    if (gap !== 1) $display("FAIL single_start_latency: got %0d expected 1", gap);
    else passed++;
    total++;
    if (ok !== 1'b1) $display("FAIL single_frame_shape: got %b expected 1", ok);
    else passed++;
    total++;
    if (d !== 8'h55) $display("FAIL single_data: got %h expected 55", d);
    else passed++;
`ifdef MMIO_UART_TX_PARITY_EN
    total++;
    if (par !== 1'b0) $display("FAIL single_parity: got %b expected 0", par);
    else passed++;
`endif
    total++;
    if (busy !== 1'b1) $display("FAIL single_busy_last_stop: got %b expected 1", busy);
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL single_busy_fall: got %b expected 0", busy);
    else passed++;
    total++;
    if (tx !== 1'b1) $display("FAIL single_tx_idle: got %b expected 1", tx);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] d0, d1;
    logic       ok0, ok1, p0, p1;
    int         g0, g1;
    bus_write(BASE, 32'h0000_00A3);
    bus_write(BASE, 32'h0000_000F);
    capture_frame(d0, ok0, p0, g0);
    capture_frame(d1, ok1, p1, g1);
    total++;
    if (ok0 !== 1'b1 || d0 !== 8'hA3) $display("FAIL b2b_first: got %h ok=%b expected a3 ok=1", d0, ok0);
    else passed++;
    total++;
    if (ok1 !== 1'b1 || d1 !== 8'h0F) $display("FAIL b2b_second: got %h ok=%b expected 0f ok=1", d1, ok1);
    else passed++;
    total++;
    if (g1 !== 1) $display("FAIL b2b_gap: got %0d expected 1", g1);
    else passed++;
`ifdef MMIO_UART_TX_PARITY_EN
    total++;
    if (p0 !== 1'b0 || p1 !== 1'b0) $display("FAIL b2b_parity: got %b%b expected 00", p0, p1);
    else passed++;
`endif
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL b2b_idle: got %b expected 0", busy);
    else passed++;
  endtask

  task automatic test_overflow;
    logic [31:0] st;
    logic [7:0]  d_arr [9];
    logic        ok_arr [9];
    logic        p;
    int          g;
    fork
      begin
        for (int i = 0; i < 10; i++) bus_write(BASE, 32'(i));
        read_reg(STATUS, st);
      end
      begin
        for (int f = 0; f < 9; f++) capture_frame(d_arr[f], ok_arr[f], p, g);
      end
    join
    total++;
    if (st !== 32'h0000_080D) $display("FAIL ovf_status_full: got %h expected 0000080d", st);
    else passed++;
    for (int f = 0; f < 9; f++) begin
      total++;
      if (ok_arr[f] !== 1'b1 || d_arr[f] !== 8'(f))
        $display("FAIL ovf_frame%0d: got %h ok=%b expected %h ok=1", f, d_arr[f], ok_arr[f], 8'(f));
      else passed++;
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0)
        $display("FAIL ovf_no_extra_frame cycle %0d: got tx=%b busy=%b expected tx=1 busy=0", i, tx, busy);
      else passed++;
    end
    read_reg(STATUS, st);
    total++;
    if (st !== 32'h0000_000A) $display("FAIL ovf_sticky: got %h expected 0000000a", st);
    else passed++;
    bus_write(STATUS, 32'h0000_0008);
    read_reg(STATUS, st);
    total++;
    if (st !== 32'h0000_0002) $display("FAIL ovf_clear: got %h expected 00000002", st);
    else passed++;
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] st;
    bus_write(BASE, 32'h0000_005A);
    repeat (18) @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b1) $display("FAIL mid_bit3: got tx=%b busy=%b expected tx=1 busy=1", tx, busy);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL mid_async_reset: got tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    read_reg(STATUS, st);
    total++;
    if (st !== 32'h0000_0002) $display("FAIL mid_status: got %h expected 00000002", st);
    else passed++;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0)
        $display("FAIL mid_residual cycle %0d: got tx=%b busy=%b expected tx=1 busy=0", i, tx, busy);
      else passed++;
    end
    // Reset while the start bit is low must still force tx high at once.
    bus_write(BASE, 32'h0000_005A);
    @(negedge clk);
    total++;
    if (tx !== 1'b0 || busy !== 1'b1) $display("FAIL start_bit: got tx=%b busy=%b expected tx=0 busy=1", tx, busy);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL start_async_reset: got tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    read_reg(STATUS, st);
    total++;
    if (st !== 32'h0000_0002) $display("FAIL start_status: got %h expected 00000002", st);
    else passed++;
  endtask

  task automatic test_decode;
    logic [31:0] st;
    logic [31:0] a_list [4];
    a_list[0] = 32'h0000_1008;
    a_list[1] = 32'h0000_0010;
    a_list[2] = 32'h0001_1000;
    a_list[3] = 32'h0000_0FFC;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_write(a_list[i], 32'h0000_00FF);
      read_reg(a_list[i], st);
      total++;
      if (st !== 32'h0) $display("FAIL decode_rd_%h: got %h expected 00000000", a_list[i], st);
      else passed++;
      read_reg(STATUS, st);
      total++;
      if (st !== 32'h0000_0002) $display("FAIL decode_status_%h: got %h expected 00000002", a_list[i], st);
      else passed++;
    end
    repeat (4) @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL decode_idle: got tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    else passed++;
    read_reg(BASE, st);
    total++;
    if (st !== 32'h0) $display("FAIL data_read: got %h expected 00000000", st);
    else passed++;
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single_frame();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_overflow();
    @(negedge clk);
    test_reset_mid_frame();
    @(negedge clk);
    test_decode();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data bus, alongside the RAM.
- Decodes the CPU's mem_addr, mem_wr_sig and mem_wr_data outputs, and supplies read data that the top level muxes onto mem_rd_data.
- Buffers bytes in a FIFO and serialises them 8N1, LSB first, on a single tx line.
- Gives programs a console output path, and gives benches an observable result channel beyond peeking register-file state.

Parameters:
- BASE_ADDR, 32'h0000_1000: byte address of the DATA register. STATUS is at BASE_ADDR+4.
- CLK_DIV, 16: clk cycles per serial bit. Legal range 2..65535.
- FIFO_DEPTH, 8: FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_sig  in  1  CPU store strobe (mem_wr_sig); sampled on the rising clk edge.
- addr  in  32  CPU data address (mem_addr).
- wr_data  in  32  CPU store data (mem_wr_data); only bits [7:0] and bit 3 are used.
- rd_data  out  32  combinational register read data; 0 when addr matches neither register.
- tx  out  1  serial output; idle high.
- busy  out  1  high while a frame is on the line (state != IDLE).

Behaviour:
- Reset (asynchronous, high):
  - FIFO emptied, state = IDLE, bit and baud counters = 0, overflow = 0.
  - tx = 1 and busy = 0 immediately, including mid-frame; the partial frame is abandoned.
- Address decode uses the full 32 bits; addresses not equal to BASE_ADDR or BASE_ADDR+4 are ignored.
- Write to DATA (wr_sig=1, addr=BASE_ADDR):
  - Pushes wr_data[7:0].
  - Accepted if count < FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and sticky overflow is set.
- Write to STATUS with wr_data[3]=1 clears overflow. Other bits are ignored. A set and a clear on the same edge: set wins.
- Read of STATUS (addr=BASE_ADDR+4), combinational:
  - bit0 = full, bit1 = empty, bit2 = busy, bit3 = overflow.
  - bits[15:8] = FIFO count, zero-extended. All other bits 0.
  - Value after reset: 32'h0000_0002.
- Read of DATA returns 0.
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH. Count is held in log2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, START, DATA, STOP. The baud counter counts 0..CLK_DIV-1; each bit lasts exactly CLK_DIV cycles.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register, go to START, baud counter = 0.
  - START: tx=0 for CLK_DIV cycles, then DATA with bit index = 0.
  - DATA: tx = shift[bit index], LSB first. Each bit lasts CLK_DIV cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. At the end of STOP:
    - FIFO non-empty: pop and go directly to START (no idle gap).
    - FIFO empty: go to IDLE.
- Latency:
  - A DATA write captured at edge E into an empty FIFO with the FSM in IDLE is popped at edge E+1.
  - tx falls at E+1.
  - One frame is 10*CLK_DIV cycles.
- tx is driven from a register (glitch-free).
- Push and pop on the same edge: count is unchanged and both pointers advance.

Optional Feature:
- Macro: MMIO_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLK_DIV cycles.
  - Frame = 11*CLK_DIV cycles.
- Not defined: no PARITY state; 8N1 frame of 10*CLK_DIV cycles.

Test Plan (CLK_DIV=4, FIFO_DEPTH=8, BASE_ADDR=32'h1000):
- Reset release, no writes -> tx=1, busy=0, STATUS read = 32'h0000_0002 for 100 cycles.
- Write 0x55 to 0x1000 at edge E:
  - tx=0 for E+1..E+4.
  - Then bits 1,0,1,0,1,0,1,0, 4 cycles each.
  - Then tx=1 for 4 cycles; busy falls at E+41.
  - With MMIO_UART_TX_PARITY_EN: parity bit = 0, busy falls at E+45.
- Write 0xA3 then 0x0F on consecutive edges -> two frames back-to-back with no gap between stop and start; the bench decodes 0xA3 then 0x0F.
- 10 DATA writes (0x00..0x09) on consecutive edges:
  - STATUS shows full=1, overflow=1, count=8.
  - 9 frames are emitted, 0x00..0x08; 0x09 is dropped.
  - Writing 32'h8 to 0x1004 clears overflow.
- Assert reset during DATA bit 3 of frame 0x5A:
  - tx=1 and busy=0 with no clk edge.
  - After release, STATUS = 32'h0000_0002 and no residual frame.
- Store to 0x1008 and to RAM addresses -> no FIFO change, rd_data=0 for those addresses.
